// File: rtl/chess_pkg.sv
// Shared chess move-generator definitions: piece codes, move flag layout,
// FIFO word geometry and the move_collector state encodings.
package chess_pkg;

  localparam logic [2:0] EMPTY   = 3'd0;
  localparam logic [2:0] PAWN    = 3'd1;
  localparam logic [2:0] KNIGHT  = 3'd2;
  localparam logic [2:0] BISHOP  = 3'd3;
  localparam logic [2:0] ROOK    = 3'd4;
  localparam logic [2:0] QUEEN   = 3'd5;
  localparam logic [2:0] KING    = 3'd6;
  localparam logic [2:0] NOTUSED = 3'd7;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // Bit positions of the flag field inside a 19-bit move word.
  localparam int INVALID    = 18;
  localparam int PROMOTE    = 17;
  localparam int PAWN_MV    = 16;
  localparam int PAWN_2SQ   = 15;
  localparam int EN_PASSANT = 14;
  localparam int CASTLE     = 13;
  localparam int CAPTURE    = 12;

  localparam int NSQ    = 64;
  localparam int SLOTS  = 8;
  localparam int MOVE_W = 19;
  localparam int FIFO_W = 160;
  localparam int CNT_W  = 8;

  localparam logic [MOVE_W-1:0] IMOV = 19'h40000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_SEL   = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_CAPT  = 3'd4;
  localparam logic [2:0] ST_EMIT  = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  typedef struct packed {
    logic [6:0] flag;
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

  function automatic logic slot_is_valid(input logic [MOVE_W-1:0] m);
    return ~m[INVALID];
  endfunction

endpackage

// File: rtl/move_collector_if.sv
// Square-array side (done/empty/FIFO/read-enable) and move-stream side
// (valid/data/ready) of the move collector.
interface move_collector_if #(
  parameter int NSQ    = chess_pkg::NSQ,
  parameter int MOVE_W = chess_pkg::MOVE_W,
  parameter int FIFO_W = chess_pkg::FIFO_W
);
  logic [NSQ-1:0]        sq_done;
  logic [NSQ-1:0]        sq_empty;
  logic [NSQ*FIFO_W-1:0] sq_fifo;
  logic [NSQ-1:0]        sq_rden;
  logic                  mv_valid;
  logic [MOVE_W-1:0]     mv_data;
  logic                  mv_ready;

  modport master (
    input  sq_done, sq_empty, sq_fifo, mv_ready,
    output sq_rden, mv_valid, mv_data
  );

  modport slave (
    output sq_done, sq_empty, sq_fifo, mv_ready,
    input  sq_rden, mv_valid, mv_data
  );
endinterface

// File: rtl/slot_picker.sv
// Priority encoder: index of the highest set bit of an 8-bit slot mask,
// plus a flag telling whether any bit is set.
module slot_picker (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any
);
  import chess_pkg::*;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = mask[i] ? 3'(i) : idx;
    end
    any = |mask;
  end
endmodule

// File: rtl/move_collector.sv
// Drains the 64 square-unit move FIFOs after a generation pass and serializes
// their valid move slots into one ready/valid stream of 19-bit moves.
module move_collector #(
  parameter int NSQ    = chess_pkg::NSQ,
  parameter int SLOTS  = chess_pkg::SLOTS,
  parameter int MOVE_W = chess_pkg::MOVE_W,
  parameter int FIFO_W = chess_pkg::FIFO_W,
  parameter int CNT_W  = chess_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  move_collector_if.master bus,
  output logic [CNT_W-1:0] move_count,
  output logic             overflow,
  output logic             list_done,
  output logic             busy
);
  import chess_pkg::*;

  localparam int IDX_W     = $clog2(NSQ);
  localparam int SLOT_BITS = SLOTS * MOVE_W;

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SLOT_BITS-1:0] word_q, word_d;
  logic [SLOTS-1:0]     mask_q, mask_d;
  logic [2:0]           slot_q, slot_d;
  logic                 mv_valid_q, mv_valid_d;
  logic [MOVE_W-1:0]    mv_data_q, mv_data_d;
  logic [NSQ-1:0]       sq_rden_q, sq_rden_d;
  logic [CNT_W-1:0]     move_count_q, move_count_d;
  logic                 overflow_q, overflow_d;
  logic                 list_done_q, list_done_d;
  logic                 busy_q, busy_d;

  logic [FIFO_W-1:0]    fifo_word_s;
  logic [SLOT_BITS-1:0] cap_slots_s;
  logic [SLOTS-1:0]     cap_mask_s;
  logic [SLOTS-1:0]     clr_mask_s;
  logic [SLOTS-1:0]     pick_mask_s;
  logic [SLOT_BITS-1:0] pick_word_s;
  logic [2:0]           pick_idx_s;
  logic                 pick_any_s;
  logic [MOVE_W-1:0]    pick_move_s;
  logic [IDX_W-1:0]     low_idx_s;
  logic                 hs_s;
  logic                 unused_pad_s;

  assign fifo_word_s  = bus.sq_fifo[FIFO_W*int'(idx_q) +: FIFO_W];
  assign cap_slots_s  = fifo_word_s[SLOT_BITS-1:0];
  assign unused_pad_s = ^fifo_word_s[FIFO_W-1:SLOT_BITS];
  assign hs_s         = mv_valid_q & bus.mv_ready;

  // Lowest-numbered square whose FIFO still holds a word.
  always_comb begin
    low_idx_s = '0;
    for (int k = NSQ - 1; k >= 0; k--) begin
      low_idx_s = bus.sq_empty[k] ? low_idx_s : IDX_W'(k);
    end
  end

  // The picker sees the fresh word's mask in CAPT and the post-handshake mask in EMIT,
  // so the next mv_data can be registered one cycle ahead.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      cap_mask_s[i] = ~cap_slots_s[MOVE_W*i + INVALID];
    end
    clr_mask_s  = mask_q & ~(SLOTS'(1) << slot_q);
    pick_mask_s = (state_q == ST_CAPT) ? cap_mask_s : clr_mask_s;
    pick_word_s = (state_q == ST_CAPT) ? cap_slots_s : word_q;
    pick_move_s = pick_word_s[MOVE_W*int'(pick_idx_s) +: MOVE_W];
  end

  slot_picker u_slot_picker (
    .mask (pick_mask_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Collection state machine and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    mask_d       = mask_q;
    slot_d       = slot_q;
    mv_valid_d   = mv_valid_q;
    mv_data_d    = mv_data_q;
    sq_rden_d    = '0;
    move_count_d = move_count_q;
    overflow_d   = overflow_q;
    list_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          move_count_d = '0;
          overflow_d   = 1'b0;
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (&bus.sq_done) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SEL: begin
        if (&bus.sq_empty) begin
          list_done_d = 1'b1;
          state_d     = ST_FIN;
        end else begin
          idx_d     = low_idx_s;
          sq_rden_d = NSQ'(1) << low_idx_s;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT: begin
        word_d     = cap_slots_s;
        mask_d     = cap_mask_s;
        slot_d     = pick_idx_s;
        mv_valid_d = pick_any_s;
        mv_data_d  = pick_any_s ? pick_move_s : '0;
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        if (mask_q == '0) begin
          mv_valid_d = 1'b0;
          state_d    = ST_SEL;
        end else if (hs_s) begin
          mask_d       = clr_mask_s;
          move_count_d = (move_count_q == {CNT_W{1'b1}}) ? move_count_q
                                                         : move_count_q + CNT_W'(1);
          overflow_d   = overflow_q | (move_count_q == {CNT_W{1'b1}});
          slot_d       = pick_idx_s;
          mv_valid_d   = pick_any_s;
          mv_data_d    = pick_any_s ? pick_move_s : '0;
          state_d      = pick_any_s ? ST_EMIT : ST_SEL;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: begin
        mv_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops everything back to an idle, empty collector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      mask_q       <= '0;
      slot_q       <= 3'd0;
      mv_valid_q   <= 1'b0;
      mv_data_q    <= '0;
      sq_rden_q    <= '0;
      move_count_q <= '0;
      overflow_q   <= 1'b0;
      list_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      slot_q       <= slot_d;
      mv_valid_q   <= mv_valid_d;
      mv_data_q    <= mv_data_d;
      sq_rden_q    <= sq_rden_d;
      move_count_q <= move_count_d;
      overflow_q   <= overflow_d;
      list_done_q  <= list_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sq_rden  = sq_rden_q;
  assign bus.mv_valid = mv_valid_q;
  assign bus.mv_data  = mv_data_q;
  assign move_count   = move_count_q;
  assign overflow     = overflow_q;
  assign list_done    = list_done_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: table of single-pass vectors plus
// hand-written stall, empty, saturation and mid-pass reset sequences.
module tb_move_collector;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] move_count;
  logic       overflow, list_done, busy;

  always #5 clk = ~clk;

  move_collector_if bus ();

  move_collector dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.master),
    .move_count (move_count),
    .overflow   (overflow),
    .list_done  (list_done),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Non-showahead FIFO model per square.
  logic [159:0] mem [64][4];
  int           wr_cnt [64];
  int           rd_ptr [64];
  logic [159:0] fq [64];
  logic         fifo_clr = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 64; k++) begin
      if (fifo_clr) begin
        rd_ptr[k] <= 0;
        fq[k]     <= '0;
      end else if (bus.sq_rden[k] && rd_ptr[k] < wr_cnt[k]) begin
        fq[k]     <= mem[k][rd_ptr[k]];
        rd_ptr[k] <= rd_ptr[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      bus.sq_empty[k]            = (rd_ptr[k] >= wr_cnt[k]);
      bus.sq_fifo[160*k +: 160]  = fq[k];
    end
  end

  // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
  int         rdy_mode = 0;
  int         rcyc = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.mv_ready = 1'b1;
      1: begin
        bus.mv_ready = pat[rcyc % 4];
        rcyc++;
      end
      default: bus.mv_ready = 1'b0;
    endcase
  end

  // Monitor sampled on the falling edge.
  logic [18:0] got [$];
  logic [63:0] rden_log [$];
  int          ld_cnt = 0, rden_bad = 0, stall_bad = 0, stall_cnt = 0;
  logic        rden_prev = 1'b0, stall_prev = 1'b0;
  logic [18:0] stall_data = '0;
  always @(negedge clk) begin
    if (bus.mv_valid && bus.mv_ready) got.push_back(bus.mv_data);
    if (list_done) ld_cnt++;
    if (bus.sq_rden != '0) begin
      rden_log.push_back(bus.sq_rden);
      if (!$onehot(bus.sq_rden) || rden_prev) rden_bad++;
    end
    rden_prev = (bus.sq_rden != '0);
    if (stall_prev && !(bus.mv_valid && bus.mv_data == stall_data)) stall_bad++;
    if (bus.mv_valid && !bus.mv_ready) stall_cnt++;
    stall_prev = bus.mv_valid && !bus.mv_ready;
    stall_data = bus.mv_data;
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] mv(input logic [6:0] f, input int from, input int to);
    return {f, 6'(from), 6'(to)};
  endfunction

  function automatic logic [18:0] inv(input int k);
    return {1'b1, 6'h2A, 6'(k), 6'(k + 1)};
  endfunction

  function automatic logic [159:0] mkword(input logic [7:0][18:0] s);
    return {8'hA5, s};
  endfunction

  task automatic clear_fifos();
    for (int k = 0; k < 64; k++) wr_cnt[k] = 0;
    fifo_clr = 1'b1;
    @(posedge clk);
    #1 fifo_clr = 1'b0;
    got.delete();
    rden_log.delete();
    ld_cnt = 0; rden_bad = 0; stall_bad = 0; stall_cnt = 0;
  endtask

  task automatic push_word(input int sq, input logic [159:0] w);
    mem[sq][wr_cnt[sq]] = w;
    wr_cnt[sq] = wr_cnt[sq] + 1;
  endtask

  task automatic run_pass(input int done_delay);
    bus.sq_done = '0;
    @(posedge clk);
    #1 start = 1'b1;
    if (done_delay == 0) bus.sq_done = '1;
    @(posedge clk);
    #1 start = 1'b0;
    if (done_delay > 0) begin
      repeat (done_delay - 1) @(posedge clk);
      #1 bus.sq_done = '1;
    end
    for (int c = 0; c < 3000 && ld_cnt == 0; c++) @(posedge clk);
    chk("pass_completes", 160'(ld_cnt != 0), 160'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.sq_done = '0;
  endtask

  typedef struct {
    int               sq_a;
    logic [159:0]     w_a;
    int               sq_b;
    logic [159:0]     w_b;
    int               n;
    int               words;
    logic [7:0][18:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0][18:0] s;

    // Vector 0: square 9, valid slots 7, 4, 0.
    s = {mv(7'h00, 9, 17), inv(1), inv(2), mv(7'h01, 9, 27), inv(3), inv(4), inv(5), mv(7'h30, 9, 1)};
    vecs[0].sq_a = 9;  vecs[0].w_a = mkword(s); vecs[0].sq_b = -1; vecs[0].w_b = '0;
    vecs[0].n = 3; vecs[0].words = 1; vecs[0].exp = '0;
    vecs[0].exp[0] = mv(7'h00, 9, 17); vecs[0].exp[1] = mv(7'h01, 9, 27); vecs[0].exp[2] = mv(7'h30, 9, 1);
    // Vector 1: squares 3 and 40, one valid slot each.
    s = {inv(6), inv(7), inv(8), inv(9), inv(10), mv(7'h04, 3, 11), inv(11), inv(12)};
    vecs[1].sq_a = 3;  vecs[1].w_a = mkword(s);
    s = {inv(13), inv(14), mv(7'h01, 40, 33), inv(15), inv(16), inv(17), inv(18), inv(19)};
    vecs[1].sq_b = 40; vecs[1].w_b = mkword(s);
    vecs[1].n = 2; vecs[1].words = 2; vecs[1].exp = '0;
    vecs[1].exp[0] = mv(7'h04, 3, 11); vecs[1].exp[1] = mv(7'h01, 40, 33);
    // Vector 2: square 63, all eight slots valid.
    for (int i = 0; i < 8; i++) s[i] = mv(7'h02, 63, i);
    vecs[2].sq_a = 63; vecs[2].w_a = mkword(s); vecs[2].sq_b = -1; vecs[2].w_b = '0;
    vecs[2].n = 8; vecs[2].words = 1;
    for (int j = 0; j < 8; j++) vecs[2].exp[j] = mv(7'h02, 63, 7 - j);
    // Vector 3: square 20 all-invalid word, square 21 valid slot 7.
    for (int i = 0; i < 8; i++) s[i] = inv(20 + i);
    vecs[3].sq_a = 20; vecs[3].w_a = mkword(s);
    s = {mv(7'h08, 21, 5), inv(30), inv(31), inv(32), inv(33), inv(34), inv(35), inv(36)};
    vecs[3].sq_b = 21; vecs[3].w_b = mkword(s);
    vecs[3].n = 1; vecs[3].words = 2; vecs[3].exp = '0;
    vecs[3].exp[0] = mv(7'h08, 21, 5);

    bus.sq_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_mv_valid", 160'(bus.mv_valid), 160'(0));
    chk("rst_rden", 160'(bus.sq_rden), 160'(0));
    chk("rst_count", 160'(move_count), 160'(0));
    chk("rst_overflow", 160'(overflow), 160'(0));
    chk("rst_list_done", 160'(list_done), 160'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      clear_fifos();
      push_word(vecs[v].sq_a, vecs[v].w_a);
      if (vecs[v].sq_b >= 0) push_word(vecs[v].sq_b, vecs[v].w_b);
      run_pass(0);
      chk($sformatf("v%0d_n_moves", v), 160'(got.size()), 160'(vecs[v].n));
      for (int j = 0; j < vecs[v].n && j < got.size(); j++)
        chk($sformatf("v%0d_move%0d", v, j), 160'(got[j]), 160'(vecs[v].exp[j]));
      chk($sformatf("v%0d_move_count", v), 160'(move_count), 160'(vecs[v].n));
      chk($sformatf("v%0d_list_done_once", v), 160'(ld_cnt), 160'(1));
      chk($sformatf("v%0d_rden_words", v), 160'(rden_log.size()), 160'(vecs[v].words));
      if (rden_log.size() > 0)
        chk($sformatf("v%0d_rden_first", v), 160'(rden_log[0]), 160'(64'(1) << vecs[v].sq_a));
      if (vecs[v].sq_b >= 0 && rden_log.size() > 1)
        chk($sformatf("v%0d_rden_second", v), 160'(rden_log[1]), 160'(64'(1) << vecs[v].sq_b));
      chk($sformatf("v%0d_rden_shape", v), 160'(rden_bad), 160'(0));
      chk($sformatf("v%0d_overflow", v), 160'(overflow), 160'(0));
      chk($sformatf("v%0d_busy_after", v), 160'(busy), 160'(0));
    end

    // Square 0 holds two words; consumer stalls with pattern 1,0,0,1.
    clear_fifos();
    s = {inv(40), mv(7'h01, 0, 8), inv(41), inv(42), inv(43), inv(44), mv(7'h00, 0, 16), inv(45)};
    push_word(0, mkword(s));
    s = {inv(46), inv(47), inv(48), inv(49), mv(7'h20, 0, 1), inv(50), inv(51), inv(52)};
    push_word(0, mkword(s));
    rdy_mode = 1;
    run_pass(0);
    rdy_mode = 0;
    chk("stall_n_moves", 160'(got.size()), 160'(3));
    if (got.size() == 3) begin
      chk("stall_move0", 160'(got[0]), 160'(mv(7'h01, 0, 8)));
      chk("stall_move1", 160'(got[1]), 160'(mv(7'h00, 0, 16)));
      chk("stall_move2", 160'(got[2]), 160'(mv(7'h20, 0, 1)));
    end
    chk("stall_seen", 160'(stall_cnt > 0), 160'(1));
    chk("stall_hold", 160'(stall_bad), 160'(0));
    chk("stall_count", 160'(move_count), 160'(3));
    chk("stall_rden_words", 160'(rden_log.size()), 160'(2));

    // All FIFOs empty, done arrives late.
    clear_fifos();
    run_pass(5);
    chk("empty_list_done_once", 160'(ld_cnt), 160'(1));
    chk("empty_count", 160'(move_count), 160'(0));
    chk("empty_no_rden", 160'(rden_log.size()), 160'(0));
    chk("empty_no_moves", 160'(got.size()), 160'(0));

    // 260 valid moves: counter saturates, overflow sets.
    clear_fifos();
    for (int sq = 0; sq < 32; sq++) begin
      for (int i = 0; i < 8; i++) s[i] = mv(7'h01, sq, i);
      push_word(sq, mkword(s));
    end
    for (int i = 0; i < 8; i++) s[i] = (i >= 4) ? mv(7'h01, 32, i) : inv(i);
    push_word(32, mkword(s));
    run_pass(0);
    chk("sat_n_moves", 160'(got.size()), 160'(260));
    if (got.size() == 260) begin
      chk("sat_first", 160'(got[0]), 160'(mv(7'h01, 0, 7)));
      chk("sat_last", 160'(got[259]), 160'(mv(7'h01, 32, 4)));
    end
    chk("sat_count", 160'(move_count), 160'(255));
    chk("sat_overflow", 160'(overflow), 160'(1));

    // Reset asserted while EMIT is stalled.
    clear_fifos();
    for (int i = 0; i < 8; i++) s[i] = mv(7'h00, 5, i);
    push_word(5, mkword(s));
    rdy_mode = 2;
    @(posedge clk);
    #1 start = 1'b1;
    bus.sq_done = '1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 50 && !bus.mv_valid; c++) @(posedge clk);
    chk("rst_mid_reach_emit", 160'(bus.mv_valid), 160'(1));
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_mv_valid", 160'(bus.mv_valid), 160'(0));
    chk("rst_mid_mv_data", 160'(bus.mv_data), 160'(0));
    chk("rst_mid_rden", 160'(bus.sq_rden), 160'(0));
    chk("rst_mid_busy", 160'(busy), 160'(0));
    chk("rst_mid_count", 160'(move_count), 160'(0));
    repeat (2) @(negedge clk);
    bus.sq_done = '0;
    rdy_mode = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_idle_after", 160'(busy), 160'(0));

    clear_fifos();
    push_word(vecs[0].sq_a, vecs[0].w_a);
    run_pass(0);
    chk("rst_clean_n_moves", 160'(got.size()), 160'(3));
    if (got.size() == 3) chk("rst_clean_move0", 160'(got[0]), 160'(vecs[0].exp[0]));
    chk("rst_clean_count", 160'(move_count), 160'(3));
    chk("rst_clean_list_done", 160'(ld_cnt), 160'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
